// File: rtl/regfile_dump_reader.sv
// Streams a contiguous range of register-file words out over a valid/ready port.
// The CPU pipeline is held for the whole dump so the range is a consistent snapshot.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  hold_cpu,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_q, lst_q, cur_d;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [ADDR_WIDTH-1:0]   out_addr_q;
  logic                    out_valid_q, out_last_q;
  logic                    done_q, err_q;

  // Stream handshake: a word moves on a rising edge where out_valid and
  // out_ready are both high; the word is held stable until that edge.
  assign cur_d = cur_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      lst_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q <= first_reg;
            lst_q <= last_reg;
            if (first_reg <= last_reg) begin
              state_q <= READ;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        READ: begin
          out_data_q  <= rd_data;
          out_addr_q  <= cur_q;
          out_last_q  <= (cur_q == lst_q);
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            // Compare before incrementing so a range ending at the top address never wraps.
            if (cur_q == lst_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cur_q   <= cur_d;
              state_q <= READ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_addr   = (state_q == IDLE) ? '0 : cur_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign hold_cpu  = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a register-file array model feeds rd_data,
// and each dump's expected word stream is built from the range rules into exp_q.
module tb_regfile_dump_reader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = 1 + AW + DW;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_reg, last_reg;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last, busy, hold_cpu, done, err;

  logic [DW-1:0] regs [32];
  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy),
    .hold_cpu(hold_cpu), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  // mode 0: ready always high, 1: four stall cycles per word, 2: random ready
  task automatic run_dump(input int first, input int last, input int mode, input bit restart);
    int  stall;
    int  n;
    bit  seen_done;
    bit  exp_err;
    fill_regs();
    exp_q.delete();
    for (int a = first; a <= last; a++)
      exp_q.push_back({(a == last) ? 1'b1 : 1'b0, 5'(a), regs[a]});
    n       = exp_q.size();
    exp_err = (first > last);
    @(negedge clk);
    start     = 1'b1;
    first_reg = 5'(first);
    last_reg  = 5'(last);
    out_ready = 1'b0;
    stall     = 0;
    seen_done = 1'b0;
    for (int k = 1; k <= BUDGET && !seen_done; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("hold_cpu", hold_cpu, 1);
      check("busy", busy, 1);
      if (done) begin
        seen_done = 1'b1;
        check("err", err, exp_err);
        check("leftover_words", exp_q.size(), 0);
        if (mode == 0) check("latency", k, 2 * n + 1);
      end else begin
        check("err_without_done", err, 0);
        if (restart && k == 3) begin
          start     = 1'b1;
          first_reg = 5'($urandom);
          last_reg  = 5'($urandom);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("extra_word", out_valid, 0);
        else check("word", {out_last, out_addr, out_data}, exp_q[0]);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (stall >= 4);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && !out_ready) stall++;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        stall = 0;
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    exp_q.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_hold", hold_cpu, 0);
    check("done_cleared", done, 0);
    check("idle_valid", out_valid, 0);
  endtask

  task automatic abort_dump();
    bit got_valid;
    fill_regs();
    @(negedge clk);
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b0;
    got_valid = 1'b0;
    for (int k = 0; k < 10 && !got_valid; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) got_valid = 1'b1;
    end
    check("valid_before_abort", got_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_hold", hold_cpu, 0);
    check("abort_data", out_data, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; out_ready = 1'b1;
    first_reg = 5'd0; last_reg = 5'd3;
    fill_regs();
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", hold_cpu, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out", {out_last, out_addr, out_data}, 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    run_dump(0, 3, 0, 1'b0);
    run_dump(5, 6, 1, 1'b0);
    run_dump(0, 31, 0, 1'b0);
    run_dump(9, 4, 0, 1'b0);
    run_dump(7, 7, 0, 1'b0);
    run_dump(2, 12, 0, 1'b1);
    run_dump(20, 31, 2, 1'b1);
    abort_dump();
    run_dump(0, 3, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int f, l;
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      run_dump(f, l, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
